// File: rtl/gpio_bank_pkg.sv
// Shared register-map addresses and reset values for the GPIO bank controller.
package gpio_bank_pkg;
    localparam int GPIO_MAX_IO = 32;

    localparam logic [2:0] GPIO_A_DIR     = 3'd0;
    localparam logic [2:0] GPIO_A_OUT     = 3'd1;
    localparam logic [2:0] GPIO_A_IN      = 3'd2;
    localparam logic [2:0] GPIO_A_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_A_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_A_STATUS  = 3'd5;
    localparam logic [2:0] GPIO_A_OUT_SET = 3'd6;
    localparam logic [2:0] GPIO_A_OUT_CLR = 3'd7;

    // Full-width reset values; users slice them down to NUM_IO.
    localparam logic [GPIO_MAX_IO-1:0] GPIO_RST_DIR    = '0;
    localparam logic [GPIO_MAX_IO-1:0] GPIO_RST_OUT    = '0;
    localparam logic [GPIO_MAX_IO-1:0] GPIO_RST_EN     = '0;
    localparam logic [GPIO_MAX_IO-1:0] GPIO_RST_STATUS = '0;
    localparam logic [GPIO_MAX_IO-1:0] GPIO_RST_RDATA  = '0;
endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the asynchronous inpad bus; q is d delayed by SYNC_STAGES clocks.
module gpio_sync
    import gpio_bank_pkg::*;
#(
    parameter int NUM_IO      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IO-1:0] d,
    output logic [NUM_IO-1:0] q
);
    logic [SYNC_STAGES-1:0][NUM_IO-1:0] chain_q, chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain_q <= '0;
        else       chain_q <= chain_d;
    end

    assign q = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: register file, pad direction/output drive, edge-detect status with
// interrupt, and a post-turnaround mask that hides pad glitches after a drive->receive change.
module gpio_bank_ctrl
    import gpio_bank_pkg::*;
#(
    parameter int NUM_IO      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [2:0]        addr,
    input  logic [NUM_IO-1:0] wdata,
    output logic [NUM_IO-1:0] rdata,
    output logic              rd_valid,
    output logic [NUM_IO-1:0] dir,
    output logic [NUM_IO-1:0] outpad,
    input  logic [NUM_IO-1:0] inpad,
    output logic              irq
);
    localparam int TURN_LOAD = SYNC_STAGES + TURN_CYCLES;
    localparam int CW        = $clog2(TURN_LOAD + 1);
    localparam logic [CW-1:0] TURN_LOAD_C = CW'(TURN_LOAD);

    logic [NUM_IO-1:0] dir_q, dir_d, out_q, out_d;
    logic [NUM_IO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NUM_IO-1:0] status_q, status_d, mask_q, mask_d, prev_q, prev_d;
    logic [NUM_IO-1:0] rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d, irq_q, irq_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NUM_IO-1:0] sync, set_bits, clr_bits, drop, rd_sel;
    logic              wr_dir;

    gpio_sync #(.NUM_IO(NUM_IO), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (inpad),
        .q     (sync)
    );

    always_comb begin
        wr_dir    = wr_en && (addr == GPIO_A_DIR);
        dir_d     = wr_dir ? wdata : dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr_en) begin
            case (addr)
                GPIO_A_OUT:     out_d     = wdata;
                GPIO_A_OUT_SET: out_d     = out_q | wdata;
                GPIO_A_OUT_CLR: out_d     = out_q & ~wdata;
                GPIO_A_RISE_EN: rise_en_d = wdata;
                GPIO_A_FALL_EN: fall_en_d = wdata;
                default: ;
            endcase
        end

        // Edges on driven or still-settling pads are not real input activity.
        prev_d   = sync;
        set_bits = ~(dir_q | mask_q) &
                   ((sync & ~prev_q & rise_en_q) | (~sync & prev_q & fall_en_q));
        clr_bits = (wr_en && (addr == GPIO_A_STATUS)) ? wdata : '0;
        status_d = (status_q & ~clr_bits) | set_bits;
        irq_d    = |status_q;

        drop = wr_dir ? (dir_q & ~wdata) : '0;
        if (|drop) begin
            mask_d = mask_q | drop;
            cnt_d  = TURN_LOAD_C;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            mask_d = (cnt_q == CW'(1)) ? '0 : mask_q;
        end else begin
            cnt_d  = cnt_q;
            mask_d = mask_q;
        end

        case (addr)
            GPIO_A_DIR:     rd_sel = dir_q;
            GPIO_A_OUT:     rd_sel = out_q;
            GPIO_A_IN:      rd_sel = sync;
            GPIO_A_RISE_EN: rd_sel = rise_en_q;
            GPIO_A_FALL_EN: rd_sel = fall_en_q;
            GPIO_A_STATUS:  rd_sel = status_q;
            default:        rd_sel = '0;
        endcase
        rdata_d    = rd_en ? rd_sel : rdata_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q      <= GPIO_RST_DIR[NUM_IO-1:0];
            out_q      <= GPIO_RST_OUT[NUM_IO-1:0];
            rise_en_q  <= GPIO_RST_EN[NUM_IO-1:0];
            fall_en_q  <= GPIO_RST_EN[NUM_IO-1:0];
            status_q   <= GPIO_RST_STATUS[NUM_IO-1:0];
            rdata_q    <= GPIO_RST_RDATA[NUM_IO-1:0];
            mask_q     <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            mask_q     <= mask_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign dir      = dir_q;
    assign outpad   = out_q;
    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-indexed behavioural model of the bank.
module tb_gpio_bank_ctrl;
    localparam int N = 8;
    localparam int S = 2;
    localparam int T = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0, rd_en = 1'b0;
    logic [2:0]   addr = '0;
    logic [N-1:0] wdata = '0, inpad = '0;
    logic [N-1:0] rdata, dir, outpad;
    logic         rd_valid, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_bank_ctrl #(.NUM_IO(N), .SYNC_STAGES(S), .TURN_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .dir(dir),
        .outpad(outpad), .inpad(inpad), .irq(irq)
    );

    // Model: registers as plain values, inpad history indexed by edges ago, mask with an absolute expiry edge.
    logic [N-1:0] m_dir = '0, m_out = '0, m_rise = '0, m_fall = '0, m_status = '0;
    logic [N-1:0] m_rdata = '0, m_mask = '0;
    logic         m_rdv = 1'b0, m_irq = 1'b0;
    logic [N-1:0] smp [0:S];
    logic [N-1:0] m_sy, m_pv, m_set, m_drop;
    int           cyc = 0, deadline = -1;

    function automatic logic [N-1:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0: return m_dir;
            3'd1: return m_out;
            3'd2: return smp[S-1];
            3'd3: return m_rise;
            3'd4: return m_fall;
            3'd5: return m_status;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dir = '0; m_out = '0; m_rise = '0; m_fall = '0; m_status = '0;
            m_rdata = '0; m_mask = '0; m_rdv = 1'b0; m_irq = 1'b0;
            cyc = 0; deadline = -1;
            for (int j = 0; j <= S; j++) smp[j] = '0;
        end else begin
            cyc++;
            m_sy  = smp[S-1];
            m_pv  = smp[S];
            m_set = ~(m_dir | m_mask) & ((m_sy & ~m_pv & m_rise) | (~m_sy & m_pv & m_fall));
            m_rdv = rd_en;
            if (rd_en) m_rdata = m_reg(addr);
            m_irq = |m_status;
            if (wr_en && addr == 3'd5) m_status = m_status & ~wdata;
            m_status = m_status | m_set;
            m_drop = (wr_en && addr == 3'd0) ? (m_dir & ~wdata) : '0;
            if (m_drop != '0) begin
                m_mask = m_mask | m_drop;
                deadline = cyc + S + T;
            end else if (cyc == deadline) begin
                m_mask = '0;
            end
            if (wr_en) begin
                case (addr)
                    3'd0: m_dir  = wdata;
                    3'd1: m_out  = wdata;
                    3'd3: m_rise = wdata;
                    3'd4: m_fall = wdata;
                    3'd6: m_out  = m_out | wdata;
                    3'd7: m_out  = m_out & ~wdata;
                    default: ;
                endcase
            end
            for (int j = S; j >= 1; j--) smp[j] = smp[j-1];
            smp[0] = inpad;
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp("model_dir", 32'(dir), 32'(m_dir));
            cmp("model_outpad", 32'(outpad), 32'(m_out));
            cmp("model_rdata", 32'(rdata), 32'(m_rdata));
            cmp("model_rd_valid", 32'(rd_valid), 32'(m_rdv));
            cmp("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic step(input logic we, input logic re, input logic [2:0] a, input logic [N-1:0] wd);
        wr_en = we; rd_en = re; addr = a; wdata = wd;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 3'd0, '0);
    endtask

    initial begin
        for (int j = 0; j <= S; j++) smp[j] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and reads of every address
        cmp("t1_dir", 32'(dir), 0);
        cmp("t1_outpad", 32'(outpad), 0);
        cmp("t1_irq", 32'(irq), 0);
        cmp("t1_rdv_idle", 32'(rd_valid), 0);
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b1, 3'(a), '0);
            cmp("t1_rdv", 32'(rd_valid), 1);
            cmp("t1_rdata", 32'(rdata), 0);
        end
        idle(1);
        cmp("t1_rdv_pulse", 32'(rd_valid), 0);

        // Output register and set/clear aliases
        step(1'b1, 1'b0, 3'd0, 8'hFF);
        cmp("t2_dir", 32'(dir), 32'hFF);
        step(1'b1, 1'b0, 3'd1, 8'hA5);
        cmp("t2_out", 32'(outpad), 32'hA5);
        step(1'b1, 1'b0, 3'd6, 8'h02);
        cmp("t2_set", 32'(outpad), 32'hA7);
        step(1'b1, 1'b0, 3'd7, 8'h80);
        cmp("t2_clr", 32'(outpad), 32'h27);
        cmp("t2_dir_hold", 32'(dir), 32'hFF);

        // Rising edge latency, irq lag, W1C
        step(1'b1, 1'b0, 3'd0, 8'h00);
        idle(6);
        step(1'b1, 1'b0, 3'd3, 8'h01);
        inpad[0] = 1'b1;
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t3_st_e1", 32'(rdata), 0);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t3_st_e2", 32'(rdata), 0);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t3_st_e3", 32'(rdata), 0);
        cmp("t3_irq_e3", 32'(irq), 0);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t3_st_e4", 32'(rdata), 32'h01);
        cmp("t3_irq_e4", 32'(irq), 1);
        step(1'b1, 1'b0, 3'd5, 8'h01);
        cmp("t3_irq_lag", 32'(irq), 1);
        idle(1);
        cmp("t3_irq_clr", 32'(irq), 0);

        // Turnaround mask hides glitches up to and including the expiry edge
        step(1'b1, 1'b0, 3'd4, 8'h01);
        step(1'b1, 1'b0, 3'd0, 8'h01);
        inpad[0] = 1'b0;
        step(1'b1, 1'b0, 3'd0, 8'h00);
        inpad[0] = 1'b1;
        idle(1);
        inpad[0] = 1'b0;
        idle(3);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t4_masked", 32'(rdata), 0);
        cmp("t4_irq", 32'(irq), 0);
        inpad[0] = 1'b1;
        idle(3);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t4_unmasked", 32'(rdata), 32'h01);
        step(1'b1, 1'b0, 3'd5, 8'hFF);

        // Set beats simultaneous W1C
        step(1'b1, 1'b0, 3'd3, 8'h00);
        step(1'b1, 1'b0, 3'd4, 8'h08);
        inpad[3] = 1'b1;
        idle(4);
        inpad[3] = 1'b0;
        idle(2);
        inpad[3] = 1'b1;
        idle(1);
        inpad[3] = 1'b0;
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t5_first_fall", 32'(rdata), 32'h08);
        idle(1);
        step(1'b1, 1'b0, 3'd5, 8'h08);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t5_set_wins", 32'(rdata), 32'h08);
        cmp("t5_irq", 32'(irq), 1);
        step(1'b1, 1'b0, 3'd5, 8'h08);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t5_w1c", 32'(rdata), 0);

        // Reset mid-turnaround with a read response outstanding
        step(1'b1, 1'b0, 3'd4, 8'h00);
        step(1'b1, 1'b0, 3'd3, 8'hFF);
        inpad = '0;
        idle(4);
        inpad = 8'hFF;
        idle(4);
        step(1'b0, 1'b1, 3'd5, '0);
        cmp("t6_status_full", 32'(rdata), 32'hFF);
        step(1'b1, 1'b0, 3'd1, 8'h5A);
        step(1'b1, 1'b0, 3'd0, 8'hFF);
        step(1'b1, 1'b0, 3'd0, 8'h00);
        rd_en = 1'b1; addr = 3'd5;
        @(posedge clk);
        #1;
        cmp("t6_rdv_pre", 32'(rd_valid), 1);
        cmp("t6_irq_pre", 32'(irq), 1);
        reset = 1'b1;
        #1;
        cmp("t6_dir", 32'(dir), 0);
        cmp("t6_outpad", 32'(outpad), 0);
        cmp("t6_rdata", 32'(rdata), 0);
        cmp("t6_rdv", 32'(rd_valid), 0);
        cmp("t6_irq", 32'(irq), 0);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            cmp("t6_no_rdv", 32'(rd_valid), 0);
        end

        // Randomized traffic; the per-cycle compare process does the checking
        for (int c = 0; c < 3000; c++) begin
            logic         we, re;
            logic [2:0]   a;
            logic [N-1:0] wd;
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 2) == 0);
            a  = 3'($urandom_range(0, 7));
            wd = N'($urandom);
            if (a == 3'd0) wd = wd & N'($urandom);
            if ($urandom_range(0, 2) == 0) inpad = inpad ^ (N'(1) << $urandom_range(0, N-1));
            step(we, re, a, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
